// File: rtl/prefetch_issue_ctrl_pkg.sv
// Shared types for the prefetch issue controller: default address width,
// address type and the controller state encoding.
package pf_pkg;

    localparam int ADDR_BITS_DFLT = 64;

    typedef logic [ADDR_BITS_DFLT-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } pf_state_t;

endpackage

// File: rtl/prefetch_issue_ctrl_if.sv
// Prefetch request channel towards the memory side (valid/ready).
// master = prefetch issuer, slave = memory side.
interface prefetch_issue_ctrl_if #(
    parameter int ADDR_BITS = pf_pkg::ADDR_BITS_DFLT
) ();

    logic                 pfValid;
    logic [ADDR_BITS-1:0] pfAddr;
    logic                 pfReady;

    modport master (output pfValid, output pfAddr, input pfReady);
    modport slave  (input pfValid, input pfAddr, output pfReady);

endinterface

// File: rtl/prefetch_issue_ctrl_addr_gen.sv
// Next-address generator: cur + stride (modulo 2^ADDR_BITS) and whether the
// result stays inside the page of base. Wrap past 0 / all-ones shows up as
// a page change, which is what stops issue at the address-space edge.
module pf_addr_gen import pf_pkg::*; #(
    parameter int ADDR_BITS = ADDR_BITS_DFLT,
    parameter int PAGE_BITS = 12
) (
    input  logic [ADDR_BITS-1:0] cur,
    input  logic [ADDR_BITS-1:0] stride,
    input  logic [ADDR_BITS-1:0] base,
    output logic [ADDR_BITS-1:0] sum,
    output logic                 samePage
);

    logic [ADDR_BITS-1:0] diff;

    assign sum      = cur + stride;
    assign diff     = sum ^ base;
    // only page-number bits matter; in-page offset bits are shifted out
    assign samePage = ((diff >> PAGE_BITS) == '0);

endmodule

// File: rtl/prefetch_issue_ctrl.sv
// Prefetch issue controller for one stride stream. A demand access with a
// non-zero stride launches up to depthCfg prefetches (base+stride, ...)
// over the pf channel, never leaving the page of the triggering access.
module prefetch_issue_ctrl import pf_pkg::*; #(
    parameter int ADDR_BITS  = ADDR_BITS_DFLT,
    parameter int DEPTH_BITS = 3,
    parameter int PAGE_BITS  = 12,
    parameter int CNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  accessValid,
    input  logic [ADDR_BITS-1:0]  accessAddr,
    input  logic [ADDR_BITS-1:0]  strideIn,
    input  logic [DEPTH_BITS-1:0] depthCfg,
    prefetch_issue_ctrl_if.master pfIf,
    output logic                  busy,
    output logic [CNT_BITS-1:0]   issuedCount
);

    pf_state_t             state;
    logic [ADDR_BITS-1:0]  base;
    logic [ADDR_BITS-1:0]  stride;
    logic [DEPTH_BITS-1:0] remaining;

    logic                  idleSel;
    logic                  trigger;
    logic                  xfer;
    logic                  sameStride;
    logic [ADDR_BITS-1:0]  agCur, agStride, agBase, agSum;
    logic                  agSamePage;
    logic [DEPTH_BITS-1:0] remAfter;

    assign idleSel    = (state == IDLE);
    assign trigger    = accessValid && (strideIn != '0) && (depthCfg != '0);
    assign xfer       = pfIf.pfValid && pfIf.pfReady;
    assign sameStride = (strideIn == stride);

    // In IDLE the generator looks at the incoming access; otherwise it
    // steps from the address currently on the channel.
    assign agCur    = idleSel ? accessAddr : pfIf.pfAddr;
    assign agStride = idleSel ? strideIn   : stride;
    assign agBase   = idleSel ? accessAddr : base;

    pf_addr_gen #(
        .ADDR_BITS (ADDR_BITS),
        .PAGE_BITS (PAGE_BITS)
    ) u_addrGen (
        .cur      (agCur),
        .stride   (agStride),
        .base     (agBase),
        .sum      (agSum),
        .samePage (agSamePage)
    );

    // Remaining count after this cycle: the transfer is counted first, then
    // a same-stride access reloads the window.
    always_comb begin
        remAfter = remaining;
        if (xfer)
            remAfter = remaining - 1'b1;
        if (accessValid && sameStride)
            remAfter = depthCfg;
    end

    // Controller FSM with registered channel outputs and statistics.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            base         <= '0;
            stride       <= '0;
            remaining    <= '0;
            pfIf.pfValid <= 1'b0;
            pfIf.pfAddr  <= '0;
            busy         <= 1'b0;
            issuedCount  <= '0;
        end else begin
            if (xfer && (issuedCount != '1))
                issuedCount <= issuedCount + 1'b1;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        base      <= accessAddr;
                        stride    <= strideIn;
                        remaining <= depthCfg;
                        // first target already outside the page: nothing to do
                        if (agSamePage) begin
                            state        <= ISSUE;
                            busy         <= 1'b1;
                            pfIf.pfValid <= 1'b1;
                            pfIf.pfAddr  <= agSum;
                        end
                    end
                end
                ISSUE: begin
                    remaining <= remAfter;
                    if (accessValid && !sameStride) begin
                        // stream changed: finish the request in flight, no more
                        if (xfer) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            pfIf.pfValid <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (xfer) begin
                        if ((remAfter != '0) && agSamePage) begin
                            pfIf.pfAddr <= agSum;
                        end else begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            pfIf.pfValid <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        pfIf.pfValid <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    pfIf.pfValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
